// File: rtl/sprite_scheduler_pkg.sv
// Shared VGA definitions for the sprite scheduler block.
// Contents:
//   H_VISIBLE_DEF / V_VISIBLE_DEF : default visible raster size (800 x 600)
//   RGB_W                         : packed colour width, {r,g,b} at 4 bits each
//   POS_W                         : scan coordinate width
//   sched_state_t                 : step sequencer FSM encoding
package sprite_scheduler_pkg;

    localparam int H_VISIBLE_DEF = 800;
    localparam int V_VISIBLE_DEF = 600;
    localparam int RGB_W         = 12;
    localparam int POS_W         = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_STEP = 1'b1
    } sched_state_t;

endpackage

// File: rtl/sprite_scheduler_if.sv
// Bundle of the sprite-side signals exchanged between the scheduler and the
// sprite widgets.
// Signals:
//   hit       : per-sprite "pixel inside sprite" flags
//   spriteRGB : sprite i colour at [12i+11:12i]
//   bgRGB     : background colour
//   enMask    : per-sprite motion enable
//   step      : one-cycle advance strobes back to the sprites
// Modports:
//   master : sprite side, drives pixel data and enables, receives step
//   slave  : scheduler side
interface sprite_scheduler_if
    import sprite_scheduler_pkg::*;
#(
    parameter int NUM_SPRITES = 4
);

    logic [NUM_SPRITES-1:0]       hit;
    logic [RGB_W*NUM_SPRITES-1:0] spriteRGB;
    logic [RGB_W-1:0]             bgRGB;
    logic [NUM_SPRITES-1:0]       enMask;
    logic [NUM_SPRITES-1:0]       step;

    modport master (
        output hit, spriteRGB, bgRGB, enMask,
        input  step
    );

    modport slave (
        input  hit, spriteRGB, bgRGB, enMask,
        output step
    );

endinterface

// File: rtl/sprite_pixel_mux.sv
// Priority colour selector: returns the colour of the lowest-index sprite
// whose hit flag is set, or the background colour when no sprite is hit.
// Purely combinational.
// Ports:
//   hit       : per-sprite hit flags
//   spriteRGB : packed sprite colours, sprite i at [12i+11:12i]
//   bgRGB     : background colour
//   colour    : selected 12-bit colour
module sprite_pixel_mux
    import sprite_scheduler_pkg::*;
#(
    parameter int NUM_SPRITES = 4
) (
    input  logic [NUM_SPRITES-1:0]       hit,
    input  logic [RGB_W*NUM_SPRITES-1:0] spriteRGB,
    input  logic [RGB_W-1:0]             bgRGB,
    output logic [RGB_W-1:0]             colour
);

    // Walk from the highest index down so the lowest set bit wins last.
    always_comb begin
        colour = bgRGB;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                colour = spriteRGB[RGB_W*i +: RGB_W];
            end
        end
    end

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite scheduler: composites the sprite/background pixel for the current
// scan position, accumulates per-frame sprite collisions, and once every
// frameDiv+1 frames issues a sequence of one-hot step strobes, one sprite
// per cycle, to advance the enabled sprites.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   X, Y                : current scan position
//   hit, spriteRGB      : per-sprite hit flags and colours
//   bgRGB               : background colour
//   enMask              : per-sprite motion enable
//   frameDiv            : motion every frameDiv+1 frames
//   step                : registered one-hot advance strobes
//   red, green, blue    : composited pixel, one cycle after X/Y
//   active              : registered visible-area flag, aligned with colour
//   collide             : collision flags of the previous frame
//   busy                : high while a step sequence is running
module sprite_scheduler
    import sprite_scheduler_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int H_VISIBLE   = H_VISIBLE_DEF,
    parameter int V_VISIBLE   = V_VISIBLE_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [POS_W-1:0]             X,
    input  logic [POS_W-1:0]             Y,
    input  logic [NUM_SPRITES-1:0]       hit,
    input  logic [RGB_W*NUM_SPRITES-1:0] spriteRGB,
    input  logic [RGB_W-1:0]             bgRGB,
    input  logic [NUM_SPRITES-1:0]       enMask,
    input  logic [3:0]                   frameDiv,
    output logic [NUM_SPRITES-1:0]       step,
    output logic [3:0]                   red,
    output logic [3:0]                   green,
    output logic [3:0]                   blue,
    output logic                         active,
    output logic [NUM_SPRITES-1:0]       collide,
    output logic                         busy
);

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SPRITES - 1);
    localparam logic [POS_W-1:0] H_LIM    = POS_W'(H_VISIBLE);
    localparam logic [POS_W-1:0] V_LIM    = POS_W'(V_VISIBLE);
    localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_VISIBLE - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_VISIBLE - 1);

    // Clearing the lowest set bit leaves something only if two or more
    // bits were set.
    function automatic logic multi_hit(input logic [NUM_SPRITES-1:0] h);
        return (h & (h - NUM_SPRITES'(1))) != '0;
    endfunction

    logic                   vis_p0;
    logic                   at_end_p0;
    logic                   frame_end_p0;
    logic [NUM_SPRITES-1:0] contrib_p0;
    logic [RGB_W-1:0]       colour_p0;

    logic                   at_end_p1;
    logic                   start_p1;
    logic [3:0]             fcnt;
    logic [NUM_SPRITES-1:0] acc;

    sched_state_t           state, state_d;
    logic [IDX_W-1:0]       idx, idx_d;
    logic [NUM_SPRITES-1:0] step_d;

    // Stage p0: scan-position decode, collision contribution, colour select
    always_comb begin
        vis_p0       = (X < H_LIM) && (Y < V_LIM);
        at_end_p0    = (X == H_LAST) && (Y == V_LAST);
        // A held end position only counts on its first cycle.
        frame_end_p0 = at_end_p0 && !at_end_p1;
        contrib_p0   = (vis_p0 && multi_hit(hit)) ? hit : '0;
    end

    sprite_pixel_mux #(
        .NUM_SPRITES (NUM_SPRITES)
    ) u_mux (
        .hit       (hit),
        .spriteRGB (spriteRGB),
        .bgRGB     (bgRGB),
        .colour    (colour_p0)
    );

    // Stage p1: registered pixel, frame counting and collision capture
    always_ff @(posedge clk) begin
        if (reset) begin
            at_end_p1 <= 1'b0;
            start_p1  <= 1'b0;
            fcnt      <= '0;
            acc       <= '0;
            collide   <= '0;
            active    <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            at_end_p1 <= at_end_p0;
            active    <= vis_p0;
            if (vis_p0) begin
                {red, green, blue} <= colour_p0;
            end else begin
                {red, green, blue} <= '0;
            end

            start_p1 <= 1'b0;
            if (frame_end_p0) begin
                if (fcnt == frameDiv) begin
                    fcnt     <= '0;
                    start_p1 <= 1'b1;
                end else begin
                    fcnt <= fcnt + 4'd1;
                end
                // The end pixel itself belongs to the frame being closed.
                collide <= acc | contrib_p0;
                acc     <= '0;
            end else begin
                acc <= acc | contrib_p0;
            end
        end
    end

    // Step sequencer: the step register is loaded with the strobe for the
    // state being entered, so step and busy line up cycle for cycle and the
    // first strobe appears two clocks after the frame end.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        step_d  = '0;
        case (state)
            ST_IDLE: begin
                if (start_p1) begin
                    state_d = ST_STEP;
                    idx_d   = '0;
                end
            end
            ST_STEP: begin
                if (idx == IDX_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        if (state_d == ST_STEP) begin
            step_d[idx_d] = enMask[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            step  <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            step  <= step_d;
        end
    end

    assign busy = (state == ST_STEP);

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler: directed scenarios with random
// pixel traffic, checked every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_sprite_scheduler;
    import sprite_scheduler_pkg::*;

    localparam int NS   = 4;
    localparam int MAXC = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] X, Y;
    logic [3:0]  frameDiv;
    logic [3:0]  red, green, blue;
    logic        active;
    logic [NS-1:0] collide;
    logic        busy;

    sprite_scheduler_if #(.NUM_SPRITES(NS)) sif ();

    sprite_scheduler #(.NUM_SPRITES(NS)) dut (
        .clk       (clk),
        .reset     (reset),
        .X         (X),
        .Y         (Y),
        .hit       (sif.hit),
        .spriteRGB (sif.spriteRGB),
        .bgRGB     (sif.bgRGB),
        .enMask    (sif.enMask),
        .frameDiv  (frameDiv),
        .step      (sif.step),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .active    (active),
        .collide   (collide),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int pulses     = 0;
    int busy_cycles = 0;

    // Reference model state
    bit          m_prev_end;
    int          m_fcnt;
    logic [NS-1:0] m_acc;
    logic [NS-1:0] m_collide;
    logic [11:0] m_rgb;
    logic        m_act;
    logic [NS-1:0] exp_step [MAXC];
    bit          exp_busy [MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Apply the current inputs for one clock, advance the model, compare.
    task automatic cycle();
        bit   vis_m, end_m, fe;
        int   nhit;
        logic [NS-1:0] contrib;
        vis_m = (X < 11'd800) && (Y < 11'd600);
        end_m = (X == 11'd799) && (Y == 11'd599);
        if (reset) begin
            m_prev_end = 1'b0;
            m_fcnt     = 0;
            m_acc      = '0;
            m_collide  = '0;
            m_rgb      = '0;
            m_act      = 1'b0;
            for (int j = cyc; j < cyc + 8; j++) begin
                exp_step[j] = '0;
                exp_busy[j] = 1'b0;
            end
        end else begin
            fe = end_m && !m_prev_end;
            m_prev_end = end_m;
            nhit = 0;
            for (int i = 0; i < NS; i++) nhit += int'(sif.hit[i]);
            contrib = (vis_m && nhit >= 2) ? sif.hit : '0;
            m_act = vis_m;
            m_rgb = '0;
            if (vis_m) begin
                m_rgb = sif.bgRGB;
                for (int i = NS - 1; i >= 0; i--)
                    if (sif.hit[i]) m_rgb = sif.spriteRGB[12*i +: 12];
            end
            if (fe) begin
                m_collide = m_acc | contrib;
                m_acc     = '0;
                if (m_fcnt == int'(frameDiv)) begin
                    m_fcnt = 0;
                    if (!exp_busy[cyc]) begin
                        for (int i = 0; i < NS; i++) begin
                            exp_step[cyc+1+i] = sif.enMask[i] ? NS'(1 << i) : '0;
                            exp_busy[cyc+1+i] = 1'b1;
                        end
                    end
                end else begin
                    m_fcnt = (m_fcnt + 1) % 16;
                end
            end else begin
                m_acc = m_acc | contrib;
            end
        end
        @(posedge clk);
        #1;
        chk("step", 32'(sif.step), 32'(exp_step[cyc]));
        chk("busy", 32'(busy), 32'(exp_busy[cyc]));
        chk("rgb", 32'({red, green, blue}), 32'(m_rgb));
        chk("active", 32'(active), 32'(m_act));
        chk("collide", 32'(collide), 32'(m_collide));
        pulses      += $countones(sif.step);
        busy_cycles += int'(busy);
        cyc++;
    endtask

    task automatic rand_pix();
        X = 11'($urandom_range(0, 1023));
        Y = 11'($urandom_range(0, 700));
        if (X == 11'd799 && Y == 11'd599) X = 11'd0;
        sif.hit       = NS'($urandom);
        sif.spriteRGB = {16'($urandom), 32'($urandom)};
        sif.bgRGB     = 12'($urandom);
    endtask

    task automatic end_pos();
        X = 11'd799;
        Y = 11'd599;
    endtask

    initial begin
        for (int j = 0; j < MAXC; j++) begin
            exp_step[j] = '0;
            exp_busy[j] = 1'b0;
        end
        reset = 1'b1;
        X = 11'd0; Y = 11'd0;
        frameDiv      = 4'd0;
        sif.hit       = 4'b1011;
        sif.spriteRGB = 48'h123_456_789_ABC;
        sif.bgRGB     = 12'h777;
        sif.enMask    = 4'b1111;
        repeat (3) cycle();
        chk("reset_step", 32'(sif.step), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rgb", 32'({red, green, blue}), 32'd0);
        chk("reset_collide", 32'(collide), 32'd0);

        // Frame end on the first cycle out of reset, frameDiv = 0
        reset = 1'b0;
        sif.hit = '0;
        pulses = 0; busy_cycles = 0;
        end_pos();
        cycle();
        X = 11'd10; Y = 11'd10;
        cycle();
        chk("first_step", 32'(sif.step), 32'h1);
        repeat (7) cycle();
        chk("div0_pulses", 32'(pulses), 32'd4);
        chk("div0_busy", 32'(busy_cycles), 32'd4);

        // Priority composite and out-of-range blanking
        X = 11'd100; Y = 11'd50;
        sif.hit       = 4'b0110;
        sif.spriteRGB = {12'h00F, 12'h0F0, 12'hF00, 12'h0FF};
        sif.bgRGB     = 12'h555;
        cycle();
        chk("mux_red", 32'(red), 32'hF);
        chk("mux_green", 32'(green), 32'h0);
        chk("mux_blue", 32'(blue), 32'h0);
        chk("mux_active", 32'(active), 32'd1);
        X = 11'd900;
        cycle();
        chk("offscreen_rgb", 32'({red, green, blue}), 32'd0);
        chk("offscreen_active", 32'(active), 32'd0);

        // Random traffic with periodic frame ends
        frameDiv = 4'($urandom_range(0, 2));
        for (int f = 0; f < 8; f++) begin
            sif.enMask = NS'($urandom);
            end_pos();
            sif.hit = NS'($urandom);
            cycle();
            repeat (40) begin
                rand_pix();
                cycle();
            end
        end

        // frameDiv = 2 over six frames, partial enable mask
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        frameDiv   = 4'd2;
        sif.enMask = 4'b0101;
        pulses = 0; busy_cycles = 0;
        for (int f = 1; f <= 6; f++) begin
            end_pos();
            sif.hit = '0;
            cycle();
            repeat (10) begin
                rand_pix();
                cycle();
            end
            if (f == 2) chk("div2_quiet_f1_f2", 32'(pulses), 32'd0);
        end
        chk("div2_pulses", 32'(pulses), 32'd4);
        chk("div2_busy", 32'(busy_cycles), 32'd8);

        // Collision capture for one frame, then a clean frame
        frameDiv   = 4'd0;
        sif.enMask = 4'b1111;
        sif.hit    = '0;
        end_pos();
        cycle();
        X = 11'd100; Y = 11'd100;
        sif.hit = 4'b0011;
        cycle();
        sif.hit = '0;
        X = 11'd10; Y = 11'd10;
        repeat (6) cycle();
        end_pos();
        cycle();
        chk("collide_frame_n", 32'(collide), 32'h3);
        X = 11'd20;
        repeat (8) cycle();
        end_pos();
        cycle();
        chk("collide_clean", 32'(collide), 32'h0);
        X = 11'd20;
        repeat (8) cycle();

        // End position held for four clocks counts once
        pulses = 0; busy_cycles = 0;
        end_pos();
        repeat (4) cycle();
        X = 11'd10;
        repeat (8) cycle();
        chk("hold_pulses", 32'(pulses), 32'd4);
        chk("hold_busy", 32'(busy_cycles), 32'd4);

        // Reset during the second step cycle, then a fresh sequence
        end_pos();
        cycle();
        X = 11'd10;
        cycle();
        cycle();
        chk("abort_second", 32'(sif.step), 32'h2);
        reset = 1'b1;
        cycle();
        chk("abort_step", 32'(sif.step), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        pulses = 0;
        repeat (4) cycle();
        chk("abort_no_tail", 32'(pulses), 32'd0);
        end_pos();
        cycle();
        X = 11'd10;
        cycle();
        chk("restart_idx0", 32'(sif.step), 32'h1);
        repeat (8) cycle();
        chk("restart_pulses", 32'(pulses), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sprite_scheduler.md
SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 SHALL take parameter NUM_SPRITES, default 4, the number of sprite widgets served.
REQ-002 SHALL take parameter H_VISIBLE, default 800, the visible pixel width.
REQ-003 SHALL take parameter V_VISIBLE, default 600, the visible line count.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock. All logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports X and Y, input, 11 bits each: the current scan position.
REQ-007 SHALL have port hit, input, NUM_SPRITES bits: per-sprite "pixel inside sprite" flags.
REQ-008 SHALL have port spriteRGB, input, 12*NUM_SPRITES bits: sprite i colour at [12i+11:12i], ordered {r,g,b} at 4 bits each.
REQ-009 SHALL have port bgRGB, input, 12 bits: the background colour.
REQ-010 SHALL have port enMask, input, NUM_SPRITES bits: per-sprite motion enable.
REQ-011 SHALL have port frameDiv, input, 4 bits: motion occurs every frameDiv+1 frames.
REQ-012 SHALL have port step, output, NUM_SPRITES bits: one-cycle advance strobes to the sprites.
REQ-013 SHALL have ports red, green and blue, output, 4 bits each: the composited pixel.
REQ-014 SHALL have port active, output, 1 bit: the registered visible-area flag.
REQ-015 SHALL have port collide, output, NUM_SPRITES bits: the previous frame's collision flags.
REQ-016 SHALL have port busy, output, 1 bit: high while a step sequence is in progress.

Function
REQ-017 SHALL define vis = (X < H_VISIBLE) && (Y < V_VISIBLE).
REQ-018 SHALL define atEnd = (X == H_VISIBLE-1) && (Y == V_VISIBLE-1).
REQ-019 SHALL raise frameEnd for exactly one cycle when atEnd is 1 and the registered atEnd of the previous cycle is 0. This rule makes a scan position held for multiple clocks count once.
REQ-020 SHALL maintain a 4-bit frame counter fcnt. On frameEnd: if fcnt == frameDiv, set fcnt to 0 and assert start; otherwise increment fcnt.
REQ-021 SHALL use a two-state FSM, IDLE and STEP, with index idx.
  - IDLE with start: go to STEP with idx = 0.
  - STEP: register step = enMask[idx] one-hot at bit idx for one cycle; if idx == NUM_SPRITES-1, go to IDLE; otherwise increment idx.
REQ-022 SHALL ignore start while in STEP; there is no queuing.
REQ-023 SHALL drive busy = 1 exactly while the FSM is in STEP.
REQ-024 SHALL drive step as a registered output. At most one bit is high per cycle, and step is all-zero in IDLE.
REQ-025 SHALL produce the first step cycle 2 clocks after the frameEnd cycle. A full sequence therefore occupies NUM_SPRITES cycles.
REQ-026 SHALL composite pixels with 1-cycle latency:
  - vis with any hit: {red,green,blue} = spriteRGB of the lowest-index set hit bit.
  - vis with no hit: {red,green,blue} = bgRGB.
  - not vis: {red,green,blue} = 0.
REQ-027 SHALL register active = vis, aligned with the colour outputs.
REQ-028 SHALL OR hit into a collision accumulator acc whenever vis is 1 and popcount(hit) >= 2.
REQ-029 SHALL, on frameEnd, load collide with acc OR'd with the current cycle's contribution, and clear acc to 0 in the same cycle.
REQ-030 SHALL use an 11-bit unsigned comparison for X and Y. Positions >= 2048 cannot occur; out-of-range values are treated as not vis.

Reset
REQ-031 SHALL, while reset is 1, set the following and hold them:
  - FSM = IDLE, idx = 0, fcnt = 0
  - acc = 0, registered atEnd = 0
  - step = 0, busy = 0, collide = 0, active = 0
  - red = green = blue = 0
REQ-032 SHALL abort any in-progress STEP sequence when reset is asserted mid-sequence. No further step pulse is emitted after the cycle in which reset is sampled.
REQ-033 SHALL count a frameEnd that occurs in the first cycle after reset deasserts normally.

Structure
REQ-034 SHALL place the FSM state encoding, H_VISIBLE and V_VISIBLE defaults, and RGB width (12) in the shared VGA package.
REQ-035 SHALL implement the priority colour selection as one sub-module, sprite_pixel_mux: combinational, NUM_SPRITES-parameterised, outputting the selected 12-bit colour.

Verification
REQ-036 SHALL cover: frameDiv = 0, enMask = 4'b1111, scan passes (799,599) -> step = 0001, 0010, 0100, 1000 on consecutive cycles starting 2 clocks after frameEnd; busy = 1 for exactly 4 cycles.
REQ-037 SHALL cover: frameDiv = 2, 6 frames -> step sequences occur only after frames 3 and 6; enMask = 4'b0101 -> only bits 0 and 2 pulse, and busy is still 4 cycles.
REQ-038 SHALL cover: (X,Y) = (100,50), hit = 4'b0110, sprite1 = 12'hF00, sprite2 = 12'h0F0 -> next cycle RGB = F,0,0 and active = 1; (X,Y) = (900,50) -> next cycle RGB = 0 and active = 0.
REQ-039 SHALL cover: hit = 4'b0011 for one visible cycle in frame N -> collide = 4'b0011 after frameN's end; a clean frame N+1 -> collide = 0 after its end.
REQ-040 SHALL cover: (799,599) held for 4 clocks -> fcnt advances once and only one sequence occurs.
REQ-041 SHALL cover: reset asserted during the second step cycle -> step = 0, busy = 0 and FSM = IDLE from the next cycle; the next frameEnd starts a fresh sequence from idx 0.
